alu_arbiter: RTL and testbench

Shares a single combinational ALU (16-bit operands, 4-bit opcode, 32-bit result) among several requesters. Each request is accepted through a valid/ready handshake and applied to the ALU from registered operands. The result is returned to the winning requester through a held valid/ready response. Round-robin arbitration guarantees that no requester starves. The block sits between the client engines and the ALU instance and is the only agent that drives the ALU inputs.

---
 rtl/alu_arbiter_pkg.sv | 15 +
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_arbiter_rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arb_pkg: shared FSM state type and default widths for the ALU arbiter
package alu_arb_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_RES_W  = 32;
    localparam int MAX_REQ    = 8;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side request/response bundle of the ALU arbiter
interface alu_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int OP_W    = ALU_OP_W,
    parameter int RES_W   = ALU_RES_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [RES_W-1:0]          rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   c;

    // first requester at or after ptr wins; later ones are masked by found
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ requesters (optional op_count via ALU_ARB_OPCOUNT_EN)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int OP_W    = ALU_OP_W,
    parameter int RES_W   = ALU_RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    output logic              alu_en,
    input  logic [RES_W-1:0]  alu_result,
`ifdef ALU_ARB_OPCOUNT_EN
    output logic [15:0]       op_count,
`endif
    output logic              busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [NUM_REQ-1:0] win_gnt;
    logic [IW-1:0]      win_idx;
    logic               hs;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    // accept in IDLE, drive the ALU in EXEC, hold the response in RESP until taken
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_idx_d     = gnt_idx_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        res_d         = res_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        alu_en        = 1'b0;
        hs            = 1'b0;
        case (state_q)
            IDLE: if (|bus.req_valid) begin
                bus.req_ready = win_gnt;
                gnt_idx_d     = win_idx;
                a_d           = bus.req_a[win_idx*DATA_W +: DATA_W];
                b_d           = bus.req_b[win_idx*DATA_W +: DATA_W];
                op_d          = bus.req_op[win_idx*OP_W +: OP_W];
                state_d       = EXEC;
            end
            EXEC: begin
                alu_en  = 1'b1;
                res_d   = alu_result;
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid[gnt_idx_q] = 1'b1;
                if (bus.rsp_ready[gnt_idx_q]) begin
                    hs      = 1'b1;
                    ptr_d   = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
        end
    end

    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_opcode     = op_q;
    assign bus.rsp_result = res_q;
    assign busy           = state_q != IDLE;

`ifdef ALU_ARB_OPCOUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // count response handshakes, sticking at the top value
    always_comb begin
        cnt_d = (hs && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // op counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign op_count = cnt_q;
`else
    logic unused_hs;
    assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, corner sequences and a random run against a transaction-level model
module tb_alu_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_en, busy;
    logic [31:0] alu_result;
`ifdef ALU_ARB_OPCOUNT_EN
    logic [15:0] op_count;
`endif

    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_en     (alu_en),
        .alu_result (alu_result),
`ifdef ALU_ARB_OPCOUNT_EN
        .op_count   (op_count),
`endif
        .busy       (busy)
    );

    // the ALU the arbiter feeds: add, subtract, multiply, else xor
    function automatic logic [31:0] alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return {16'h0, a} + {16'h0, b};
            4'd1:    return {16'h0, a} - {16'h0, b};
            4'd2:    return {16'h0, a} * {16'h0, b};
            default: return {16'h0, a ^ b};
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_opcode);

    int checks = 0;
    int errors = 0;
    int grants[$];

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*16 +: 16]  = a;
        bus.req_b[i*16 +: 16]  = b;
        bus.req_op[i*4 +: 4]   = op;
    endtask

    task automatic do_reset();
        next();
        rst_n = 1'b0;
        clear();
        next();
        next();
        rst_n = 1'b1;
    endtask

    // one complete operation from a single requester, checking every stage
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input int hold, input logic [31:0] exp);
        int n;
        next();
        set_req(idx, a, b, op);
        bus.rsp_ready = (hold == 0) ? 4'hF : 4'h0;
        #4;
        n = 0;
        while (bus.req_ready == '0 && n < 8) begin
            next();
            #4;
            n++;
        end
        chk("accept_ready", 32'(bus.req_ready), 32'(oh(idx)));
        chk("accept_alu_en", 32'(alu_en), 32'd0);
        next();
        bus.req_valid = '0;
        #4;
        chk("exec_alu_en", 32'(alu_en), 32'd1);
        chk("exec_alu_a", 32'(alu_a), 32'(a));
        chk("exec_alu_b", 32'(alu_b), 32'(b));
        chk("exec_alu_op", 32'(alu_opcode), 32'(op));
        chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        next();
        #4;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh(idx)));
        chk("rsp_result", bus.rsp_result, exp);
        chk("rsp_alu_en", 32'(alu_en), 32'd0);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                next();
                set_req((idx + 1) % N, 16'h1, 16'h1, 4'h0);
                #4;
                chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'(oh(idx)));
                chk("hold_rsp_result", bus.rsp_result, exp);
                chk("hold_no_grant", 32'(bus.req_ready), 32'd0);
            end
            next();
            bus.req_valid = '0;
            bus.rsp_ready = 4'hF;
            #4;
            chk("release_rsp_valid", 32'(bus.rsp_valid), 32'(oh(idx)));
        end
        next();
        #4;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    // random traffic checked against latency/round-robin rules at transaction level
    task automatic run_model(input int cycles, input int pv, input bit full_ready);
        bit          pend[N];
        logic [15:0] ra[N], rb[N];
        logic [3:0]  ro[N];
        logic [15:0] sa, sb;
        logic [3:0]  so;
        logic [31:0] er;
        logic [3:0]  erv;
        int          mptr, acc, w, win, j;
        bit          outst;
        mptr = 0; acc = 0; w = 0; outst = 0; er = '0; sa = '0; sb = '0; so = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; ra[i] = '0; rb[i] = '0; ro[i] = '0;
        end
        do_reset();
        grants.delete();
        for (int c = 0; c < cycles; c++) begin
            next();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(99) < pv) begin
                    pend[i] = 1;
                    ra[i] = 16'($urandom);
                    rb[i] = 16'($urandom);
                    ro[i] = 4'($urandom_range(15));
                end
                bus.req_valid[i]      = pend[i];
                bus.req_a[i*16 +: 16] = ra[i];
                bus.req_b[i*16 +: 16] = rb[i];
                bus.req_op[i*4 +: 4]  = ro[i];
            end
            bus.rsp_ready = full_ready ? 4'hF : 4'($urandom);
            #4;
            win = -1;
            if (!outst)
                for (int k = 0; k < N; k++) begin
                    j = (mptr + k) % N;
                    if (win < 0 && pend[j]) win = j;
                end
            chk("rnd_ready", 32'(bus.req_ready), win >= 0 ? 32'(oh(win)) : 32'd0);
            chk("rnd_alu_en", 32'(alu_en), 32'(outst && c == acc + 1));
            if (outst && c == acc + 1) begin
                chk("rnd_alu_a", 32'(alu_a), 32'(sa));
                chk("rnd_alu_b", 32'(alu_b), 32'(sb));
                chk("rnd_alu_op", 32'(alu_opcode), 32'(so));
            end
            erv = (outst && c >= acc + 2) ? oh(w) : 4'h0;
            chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(erv));
            if (erv != 4'h0) begin
                chk("rnd_rsp_result", bus.rsp_result, er);
                if (bus.rsp_ready[w]) begin
                    outst = 0;
                    mptr  = (w + 1) % N;
                end
            end
            if (win >= 0) begin
                outst = 1;
                acc   = c;
                w     = win;
                sa    = ra[w];
                sb    = rb[w];
                so    = ro[w];
                er    = alu_ref(sa, sb, so);
                pend[w] = 0;
                grants.push_back(w);
            end
        end
    endtask

    initial begin
        vecs[0] = '{0, 16'd5,    16'd3,    4'd0, 0, 32'h0000_0008};
        vecs[1] = '{1, 16'd100,  16'd1,    4'd1, 0, 32'h0000_0063};
        vecs[2] = '{2, 16'hFFFF, 16'hFFFF, 4'd2, 0, 32'hFFFE_0001};
        vecs[3] = '{3, 16'h00F0, 16'h0FF0, 4'd4, 0, 32'h0000_0F00};
        vecs[4] = '{0, 16'hFFFF, 16'h0001, 4'd0, 0, 32'h0001_0000};
        vecs[5] = '{2, 16'h0000, 16'h0001, 4'd1, 5, 32'hFFFF_FFFF};

        clear();
        #3;
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_alu_en", 32'(alu_en), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_b", 32'(alu_b), 32'd0);
        chk("reset_alu_op", 32'(alu_opcode), 32'd0);
        next();
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++)
            do_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].hold, vecs[v].exp);

        // ptr sits at 3 after req2; req0 and req1 both valid must grant req0
        do_op(2, 16'd7, 16'd9, 4'd0, 0, 32'd16);
        next();
        set_req(0, 16'h1234, 16'h0001, 4'h1);
        set_req(1, 16'h5555, 16'h0002, 4'h0);
        bus.rsp_ready = 4'hF;
        #4;
        chk("wrap_grant", 32'(bus.req_ready), 32'(oh(0)));
        next();
        bus.req_valid = '0;
        #4;
        chk("wrap_exec_a", 32'(alu_a), 32'h1234);
        chk("rst_pre_alu_en", 32'(alu_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        next();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            #4;
            chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

`ifdef ALU_ARB_OPCOUNT_EN
        chk("opcount_reset", 32'(op_count), 32'd0);
        for (int i = 0; i < 10; i++)
            do_op(i % N, 16'(i), 16'd2, 4'd0, 0, 32'(i + 2));
        chk("opcount_ten", 32'(op_count), 32'd10);
`endif

        run_model(40, 100, 1'b1);
        if (grants.size() < 5) chk("rotation_count", 32'(grants.size()), 32'd5);
        else
            for (int i = 0; i < 5; i++)
                chk("rotation_order", 32'(grants[i]), 32'(i % N));

        run_model(1500, 30, 1'b0);

`ifdef ALU_ARB_OPCOUNT_EN
        do_reset();
        force dut.cnt_q = 16'hFFFF;
        next();
        release dut.cnt_q;
        do_op(1, 16'd1, 16'd1, 4'd0, 0, 32'd2);
        chk("opcount_saturate", 32'(op_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
